// File: rtl/mem_stage_sram_ctrl.sv
// Memory-stage controller: splits each 32-bit load/store into two 16-bit SRAM
// accesses (low half first) and holds ready low until the access has finished.
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR     = 1024,
  parameter int SRAM_ADDR_W   = 18,
  parameter int ACCESS_CYCLES = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in
);

  localparam int WW = SRAM_ADDR_W - 1;
  localparam int CW = $clog2(ACCESS_CYCLES + 1);
  // WAIT runs WAIT_LAST+1 cycles; only meaningful when ACCESS_CYCLES > 4.
  localparam logic [CW-1:0] WAIT_LAST = CW'(ACCESS_CYCLES > 4 ? ACCESS_CYCLES - 5 : 0);

  typedef enum logic [2:0] {IDLE, LO, HI, WAIT, DONE} state_t;

  state_t          state, state_nxt;
  logic            req;
  logic [31:0]     offset;
  logic [WW-1:0]   word_idx;
  logic [WW-1:0]   word_q;
  logic            write_q;
  logic [31:0]     wdata_q;
  logic [CW-1:0]   wait_cnt;
  logic            unused_offset_bits;

  assign req      = rd_en | wr_en;
  assign offset   = address - 32'(BASE_ADDR);
  assign word_idx = offset[SRAM_ADDR_W:2];
  assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operation, word index and store data are frozen on leaving IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      read_data <= '0;
    end else begin
      if (state == IDLE && req) begin
        word_q  <= word_idx;
        write_q <= wr_en;
        wdata_q <= write_data;
      end
      if (state == HI)        wait_cnt <= WAIT_LAST;
      else if (state == WAIT) wait_cnt <= wait_cnt - CW'(1);
      if (!write_q) begin
        if (state == LO) read_data[15:0]  <= sram_dq_in;
        if (state == HI) read_data[31:16] <= sram_dq_in;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = LO;
      LO:      state_nxt = HI;
      HI:      state_nxt = (ACCESS_CYCLES > 4) ? WAIT : DONE;
      WAIT:    if (wait_cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready       = 1'b0;
    sram_addr   = {word_q, state == HI};
    sram_we_n   = 1'b1;
    sram_dq_oe  = 1'b0;
    sram_dq_out = '0;
    case (state)
      IDLE:    ready = ~req;
      DONE:    ready = 1'b1;
      LO, HI: begin
        if (write_q) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = (state == HI) ? wdata_q[31:16] : wdata_q[15:0];
        end
      end
      default: ready = 1'b0;
    endcase
    if (rst) ready = 1'b1;
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: directed cases plus randomized
// traffic against a word-level memory model, on ACCESS_CYCLES=6 and =4 instances.
module tb_mem_stage_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en, sel4;
  logic [31:0] address, write_data;

  logic [31:0] read_data6, read_data4;
  logic        ready6, ready4;
  logic [17:0] sram_addr6, sram_addr4;
  logic        we_n6, we_n4, oe6, oe4;
  logic [15:0] dq_out6, dq_out4, dq_in6, dq_in4;

  logic [15:0] sram6 [1024];
  logic [15:0] sram4 [1024];

  int total = 0;
  int bad   = 0;

  logic [31:0] ref6 [int];
  logic [31:0] ref4 [int];
  logic [31:0] exp_rd [2];

  always #5 clk = ~clk;

  mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .ACCESS_CYCLES(6)) dut6 (
    .clk(clk), .rst(rst), .rd_en(rd_en & ~sel4), .wr_en(wr_en & ~sel4),
    .address(address), .write_data(write_data), .read_data(read_data6), .ready(ready6),
    .sram_addr(sram_addr6), .sram_we_n(we_n6), .sram_dq_out(dq_out6), .sram_dq_oe(oe6),
    .sram_dq_in(dq_in6));

  mem_stage_sram_ctrl #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .ACCESS_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .rd_en(rd_en & sel4), .wr_en(wr_en & sel4),
    .address(address), .write_data(write_data), .read_data(read_data4), .ready(ready4),
    .sram_addr(sram_addr4), .sram_we_n(we_n4), .sram_dq_out(dq_out4), .sram_dq_oe(oe4),
    .sram_dq_in(dq_in4));

  // Asynchronous-read SRAMs, written on the rising edge while the strobe is low.
  assign dq_in6 = sram6[sram_addr6[9:0]];
  assign dq_in4 = sram4[sram_addr4[9:0]];
  always @(posedge clk) begin
    if (!we_n6) sram6[sram_addr6[9:0]] <= dq_out6;
    if (!we_n4) sram4[sram_addr4[9:0]] <= dq_out4;
  end

  logic [31:0] read_data_m;
  logic        ready_m, we_n_m, oe_m;
  logic [17:0] sram_addr_m;
  logic [15:0] dq_out_m;
  assign read_data_m = sel4 ? read_data4 : read_data6;
  assign ready_m     = sel4 ? ready4     : ready6;
  assign we_n_m      = sel4 ? we_n4      : we_n6;
  assign oe_m        = sel4 ? oe4        : oe6;
  assign sram_addr_m = sel4 ? sram_addr4 : sram_addr6;
  assign dq_out_m    = sel4 ? dq_out4    : dq_out6;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_ready", ready_m, 1);
      check("idle_we_n", we_n_m, 1);
      check("idle_oe", oe_m, 0);
      @(posedge clk); #1;
    end
  endtask

  // Called just after a rising edge with the DUT in IDLE; returns just after the DONE edge.
  task automatic access(input bit use4, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] data);
    int          lat;
    int          done_k;
    logic [31:0] off;
    logic [16:0] w;
    bit          is_wr;
    lat    = use4 ? 3 : 5;
    done_k = -1;
    off    = addr - 32'd1024;
    w      = off[18:2];
    is_wr  = wr;
    sel4 = use4; rd_en = rd; wr_en = wr; address = addr; write_data = data;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) check("req_seen_busy", ready_m, 0);
      if (k == 1 || k == 2) begin
        check("sram_addr", sram_addr_m, {w, (k == 2)});
        check("we_n", we_n_m, !is_wr);
        check("oe", oe_m, is_wr);
        if (is_wr) check("dq_out", dq_out_m, (k == 1) ? data[15:0] : data[31:16]);
        address = $urandom; write_data = $urandom;
      end
      if (k >= 3) check("late_we_n", we_n_m, 1);
      if (k >= 1 && ready_m) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    check("latency", done_k, lat);
    if (is_wr) begin
      if (use4) ref4[int'(w)] = data;
      else      ref6[int'(w)] = data;
    end else if (use4) begin
      exp_rd[1] = ref4.exists(int'(w)) ? ref4[int'(w)] : 32'h0;
    end else begin
      exp_rd[0] = ref6.exists(int'(w)) ? ref6[int'(w)] : 32'h0;
    end
    check("read_data", read_data_m, exp_rd[use4]);
    @(posedge clk); #1;
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram6[i] = '0;
      sram4[i] = '0;
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; sel4 = 1'b0;
    address = '0; write_data = '0;

    // Reset
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready6", ready6, 1);
    check("rst_ready4", ready4, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_we_n", we_n6, 1);
    check("rst_oe", oe6, 0);
    check("rst_addr", sram_addr6, 0);
    check("rst_dq_out", dq_out6, 0);
    check("rst_read_data6", read_data6, 0);
    check("rst_read_data4", read_data4, 0);
    check("rst_idle_ready", ready6, 1);
    @(posedge clk); #1;

    // Store/load at the base address, then back-to-back store/load at 1028
    access(0, 0, 1, 32'd1024, 32'hDEAD_BEEF);
    idle(1);
    access(0, 1, 0, 32'd1024, 32'h0);
    access(0, 0, 1, 32'd1028, 32'h1234_5678);
    access(0, 1, 0, 32'd1028, 32'h0);

    // Word index wraps modulo 2^17; addresses below the base wrap to the top
    access(0, 0, 1, 32'd1024 + (32'd1 << 19) + 32'd20, 32'hCAFE_0001);
    access(0, 1, 0, 32'd1044, 32'h0);
    access(0, 0, 1, 32'd1020, 32'h0F0F_7777);
    access(0, 1, 0, 32'd1020 + (32'd1 << 19), 32'h0);

    // rd_en=wr_en=1 behaves as a store and leaves read_data alone
    access(0, 1, 1, 32'd1032, 32'hA5A5_5A5A);
    access(0, 1, 0, 32'd1032, 32'h0);

    // Randomized traffic with the low address bits scrambled
    for (int i = 0; i < 40; i++) begin
      int op;
      int wd;
      op = $urandom_range(0, 2);
      wd = $urandom_range(0, 63);
      access(0, op != 1, op != 0, 32'd1024 + 32'(wd * 4) + 32'($urandom_range(0, 3)), $urandom);
      idle($urandom_range(0, 2));
    end

    // Reset asserted during HI of a store
    sel4 = 1'b0; wr_en = 1'b1; address = 32'd1024 + 32'd1200; write_data = 32'h0BAD_F00D;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("hi_strobe", we_n6, 0);
    #1 rst = 1'b1;
    #1 check("rst_ready_mid", ready6, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_we_n", we_n6, 1);
    check("abort_oe", oe6, 0);
    check("abort_ready", ready6, 1);
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_ready", ready6, 1);
      check("post_rst_we_n", we_n6, 1);
      check("post_rst_read_data", read_data6, 0);
      @(posedge clk); #1;
    end

    // ACCESS_CYCLES=4 instance: ready three cycles after the request
    access(1, 1, 1, 32'd1032, 32'hA5A5_5A5A);
    access(1, 1, 0, 32'd1032, 32'h0);
    access(1, 0, 1, 32'd1100, 32'h7E57_0042);
    idle(1);
    access(1, 1, 0, 32'd1100, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
